// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync pattern, MSB-first payload, then idle gap bits.
// Optional even-parity bit after the payload when PARITY_EN is defined.
module sync_frame_tx #(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 5,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 5'b11001,
  parameter int                GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dout,
  output logic              dvalid,
  output logic              sof,
  output logic              eof
);

  localparam int M1   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAXV = (M1 > GAP_BITS) ? M1 : GAP_BITS;
  localparam int CW   = $clog2(MAXV + 1);

  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
`ifdef PARITY_EN
    PAR,
`endif
    GAP
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   word;
  logic [SYNC_W-1:0]   syn;
`ifdef PARITY_EN
  logic                par;
`endif

  assign in_ready = (state == IDLE) & ~rst;

  // Outputs are registered from the current state, so each state's bit
  // appears on dout one edge after that state is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      word   <= '0;
      syn    <= '0;
      dout   <= 1'b0;
      dvalid <= 1'b0;
      sof    <= 1'b0;
      eof    <= 1'b0;
`ifdef PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      dout   <= 1'b0;
      dvalid <= 1'b0;
      sof    <= 1'b0;
      eof    <= 1'b0;
      case (state)
        IDLE: if (in_valid && in_ready) begin
          word  <= in_data;
          syn   <= SYNC_PAT;
          state <= SYNC;
          cnt   <= SYNC_LAST;
`ifdef PARITY_EN
          par   <= ^in_data;
`endif
        end
        SYNC: begin
          dout   <= syn[SYNC_W-1];
          dvalid <= 1'b1;
          sof    <= (cnt == SYNC_LAST);
          syn    <= syn << 1;
          if (cnt == '0) begin
            state <= DATA;
            cnt   <= DATA_LAST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          dout   <= word[DATA_W-1];
          dvalid <= 1'b1;
          word   <= word << 1;
          if (cnt == '0) begin
`ifdef PARITY_EN
            state <= PAR;
`else
            eof <= 1'b1;
            if (GAP_BITS == 0) state <= IDLE;
            else begin
              state <= GAP;
              cnt   <= GAP_LAST;
            end
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef PARITY_EN
        PAR: begin
          dout   <= par;
          dvalid <= 1'b1;
          eof    <= 1'b1;
          if (GAP_BITS == 0) state <= IDLE;
          else begin
            state <= GAP;
            cnt   <= GAP_LAST;
          end
        end
`endif
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx (default parameters; honours PARITY_EN).
module tb_sync_frame_tx;
`ifdef PARITY_EN
  localparam int FLEN = 14;
`else
  localparam int FLEN = 13;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, dout, dvalid, sof, eof;
  int         checks = 0;
  int         fails = 0;
  logic [4:0] det = 5'b0;
  logic       y;

  sync_frame_tx dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .dvalid(dvalid), .sof(sof), .eof(eof)
  );

  always #5 clk = ~clk;

  // Downstream overlapping 11001 detector model fed by dout.
  always @(posedge clk) det <= rst ? 5'b0 : {det[3:0], dout};
  assign y = ({det[3:0], dout} == 5'b11001);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FLEN-1:0] build_exp(input logic [7:0] w);
`ifdef PARITY_EN
    return {5'b11001, w, ^w};
`else
    return {5'b11001, w};
`endif
  endfunction

  // Accept one word and capture the FLEN output cycles that follow.
  task automatic run_frame(input logic [7:0] w, output logic [FLEN-1:0] d, v, s, e, yv,
                           output bit ok);
    ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < FLEN; i++) begin
      step();
      d[FLEN-1-i]  = dout;
      v[FLEN-1-i]  = dvalid;
      s[FLEN-1-i]  = sof;
      e[FLEN-1-i]  = eof;
      yv[FLEN-1-i] = y;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++; if ({dout, dvalid, sof, eof} !== 4'b0) begin
      fails++; $display("FAIL reset_outputs: got %b expected 0000", {dout, dvalid, sof, eof});
    end
    checks++; if (in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready_low: got %b expected 0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready_release: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_frame();
    logic [FLEN-1:0] d, v, s, e, yv;
    bit ok;
    run_frame(8'hA5, d, v, s, e, yv, ok);
    checks++; if (!ok) begin
      fails++; $display("FAIL frame_accept: got no accept expected accept");
    end
`ifdef PARITY_EN
    checks++; if (d !== 14'b1100110100101_0) begin
      fails++; $display("FAIL frame_a5_bits: got %b expected %b", d, 14'b11001101001010);
    end
`else
    checks++; if (d !== 13'b1100110100101) begin
      fails++; $display("FAIL frame_a5_bits: got %b expected %b", d, 13'b1100110100101);
    end
`endif
    checks++; if (v !== {FLEN{1'b1}}) begin
      fails++; $display("FAIL frame_dvalid: got %b expected all ones", v);
    end
    checks++; if (s !== {1'b1, {(FLEN-1){1'b0}}}) begin
      fails++; $display("FAIL frame_sof: got %b expected first bit only", s);
    end
    checks++; if (e !== FLEN'(1)) begin
      fails++; $display("FAIL frame_eof: got %b expected last bit only", e);
    end
    step();
    checks++; if ({dout, dvalid, in_ready} !== 3'b000) begin
      fails++; $display("FAIL gap1: got dout/dvalid/ready %b expected 000", {dout, dvalid, in_ready});
    end
    step();
    checks++; if ({dout, dvalid} !== 2'b00) begin
      fails++; $display("FAIL gap2: got dout/dvalid %b expected 00", {dout, dvalid});
    end
    checks++; if (in_ready !== 1'b1) begin
      fails++; $display("FAIL gap_ready: got %b expected 1", in_ready);
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [FLEN-1:0] d, v, s, e, yv;
    bit ok;
    run_frame(8'h07, d, v, s, e, yv, ok);
    checks++; if (d !== 14'b11001_00000111_1) begin
      fails++; $display("FAIL parity_07_bits: got %b expected %b", d, 14'b11001000001111);
    end
    checks++; if (e !== 14'b1) begin
      fails++; $display("FAIL parity_07_eof: got %b expected eof on parity bit", e);
    end
    run_frame(8'hA5, d, v, s, e, yv, ok);
    checks++; if (d[0] !== 1'b0) begin
      fails++; $display("FAIL parity_a5: got %b expected 0", d[0]);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic dh [0:79];
    int first = -1;
    int second = -1;
    logic [FLEN-1:0] f1, f2;
    for (int i = 0; i < 80; i++) dh[i] = 1'b0;
    in_data  = 8'hFF;
    in_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      step();
      dh[c] = dout;
      if (sof) begin
        if (first < 0) begin
          first   = c;
          in_data = 8'h00;
        end else if (second < 0) begin
          second   = c;
          in_valid = 1'b0;
        end
      end
      if (second >= 0 && c == second + FLEN - 1) break;
    end
    in_valid = 1'b0;
    checks++; if (first < 0 || second < 0) begin
      fails++; $display("FAIL b2b_sof_seen: got first=%0d second=%0d expected both found", first, second);
    end
    checks++; if (second - first !== FLEN + 3) begin
      fails++; $display("FAIL b2b_period: got %0d expected %0d", second - first, FLEN + 3);
    end
    f1 = '0;
    f2 = '0;
    if (first >= 0 && second >= 0 && second + FLEN <= 80) begin
      for (int i = 0; i < FLEN; i++) begin
        f1[FLEN-1-i] = dh[first + i];
        f2[FLEN-1-i] = dh[second + i];
      end
    end
    checks++; if (f1 !== build_exp(8'hFF)) begin
      fails++; $display("FAIL b2b_frame_ff: got %b expected %b", f1, build_exp(8'hFF));
    end
    checks++; if (f2 !== build_exp(8'h00)) begin
      fails++; $display("FAIL b2b_frame_00: got %b expected %b", f2, build_exp(8'h00));
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset_mid_frame();
    logic [FLEN-1:0] d, v, s, e, yv;
    bit ok;
    bit stray = 1'b0;
    in_data  = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !in_ready; i++) step();
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();  // now showing 4th payload bit
    checks++; if (dvalid !== 1'b1) begin
      fails++; $display("FAIL rstmid_inframe: got dvalid %b expected 1", dvalid);
    end
    rst = 1'b1;
    step();
    checks++; if ({dout, dvalid, eof, in_ready} !== 4'b0000) begin
      fails++; $display("FAIL rstmid_abort: got dout/dvalid/eof/ready %b expected 0000",
                        {dout, dvalid, eof, in_ready});
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (dvalid || eof || sof) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin
      fails++; $display("FAIL rstmid_quiet: got activity %b expected 0", stray);
    end
    run_frame(8'h3C, d, v, s, e, yv, ok);
    checks++; if (d !== build_exp(8'h3C) || v !== {FLEN{1'b1}}) begin
      fails++; $display("FAIL rstmid_3c: got %b/%b expected %b/all ones", d, v, build_exp(8'h3C));
    end
    checks++; if (e !== FLEN'(1) || s !== {1'b1, {(FLEN-1){1'b0}}}) begin
      fails++; $display("FAIL rstmid_3c_marks: got sof %b eof %b expected first/last", s, e);
    end
  endtask

  task automatic test_loopback();
    logic [FLEN-1:0] d, v, s, e, yv;
    bit ok;
    logic [7:0] w;
    for (int f = 0; f < 6; f++) begin
      w = 8'($urandom_range(0, 255));
      run_frame(w, d, v, s, e, yv, ok);
      checks++; if (yv[FLEN-5] !== 1'b1) begin
        fails++; $display("FAIL loopback_y word %h: got %b expected 1", w, yv[FLEN-5]);
      end
      checks++; if (d !== build_exp(w)) begin
        fails++; $display("FAIL loopback_bits word %h: got %b expected %b", w, d, build_exp(w));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    test_reset();
    test_frame();
`ifdef PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
